// File: rtl/microsecond_alarm_timer.sv
// microsecond_alarm_timer: memory-mapped one-shot alarm driven by the free-running
// microsecond count. CPU loads DELAY, writes START, and gets a level IRQ once the
// count reaches I_COUNT(start) + DELAY, using a wrap-safe compare.
// Optional feature: define MICROSECOND_ALARM_TIMER_PERIODIC_EN for periodic mode
// (CTRL bit3 PERIODIC, STATUS bit2 PERIODIC, STATUS bit3 sticky OVERRUN).
module microsecond_alarm_timer #(
  parameter int P_WIDTH      = 32,
  parameter int P_ADDR_WIDTH = 2
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic [P_WIDTH-1:0]      I_COUNT,
  input  logic                    I_WRITE_EN,
  input  logic                    I_READ_EN,
  input  logic [P_ADDR_WIDTH-1:0] I_ADDR,
  input  logic [P_WIDTH-1:0]      I_DATA,
  output logic [P_WIDTH-1:0]      O_READ_DATA,
  output logic                    O_IRQ
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  localparam logic [P_ADDR_WIDTH-1:0] A_CTRL   = P_ADDR_WIDTH'(0);
  localparam logic [P_ADDR_WIDTH-1:0] A_DELAY  = P_ADDR_WIDTH'(1);
  localparam logic [P_ADDR_WIDTH-1:0] A_STATUS = P_ADDR_WIDTH'(2);
  localparam logic [P_ADDR_WIDTH-1:0] A_SNAP   = P_ADDR_WIDTH'(3);

  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] delay_q, delay_d;
  logic [P_WIDTH-1:0] deadline_q, deadline_d;
  logic [P_WIDTH-1:0] snap_q, snap_d;
  logic [P_WIDTH-1:0] rdata_q, rdata_d;
  logic               irq_q, irq_d;
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
  logic               periodic_q, periodic_d;
  logic               overrun_q, overrun_d;
`endif

  logic               ctrl_wr;
  logic               delay_wr;
  logic [P_WIDTH-1:0] diff;
  logic               fire;
  logic [P_WIDTH-1:0] status;
  logic               unused_data_msb;

  // Bus decode and the wrap-safe "count has reached deadline" test
  always_comb begin
    ctrl_wr         = I_WRITE_EN && (I_ADDR == A_CTRL);
    delay_wr        = I_WRITE_EN && (I_ADDR == A_DELAY);
    diff            = I_COUNT - deadline_q;
    fire            = (state_q == S_ARMED) && !diff[P_WIDTH-1];
    unused_data_msb = I_DATA[P_WIDTH-1];
  end

  // STATUS register image
  always_comb begin
    status    = '0;
    status[0] = (state_q == S_ARMED);
    status[1] = (state_q == S_FIRED);
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
    status[2] = periodic_q;
    status[3] = overrun_q;
`endif
  end

  // Next-state: CTRL writes take precedence over a coincident fire; within a
  // CTRL write, IRQ_ACK is applied first, then STOP beats START.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    deadline_d = deadline_q;
    snap_d     = snap_q;
    rdata_d    = rdata_q;
    irq_d      = irq_q;
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
    periodic_d = periodic_q;
    overrun_d  = overrun_q;
`endif

    if (delay_wr) begin
      delay_d = {1'b0, I_DATA[P_WIDTH-2:0]};
    end

    if (ctrl_wr) begin
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
      periodic_d = I_DATA[3];
`endif
      if (I_DATA[2]) begin
        irq_d = 1'b0;
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
        overrun_d = 1'b0;
`endif
        if (state_q == S_FIRED) begin
          state_d = S_IDLE;
        end
      end
      if (I_DATA[1]) begin
        state_d = S_IDLE;
      end else if (I_DATA[0]) begin
        state_d    = S_ARMED;
        deadline_d = I_COUNT + delay_q;
      end
    end else if (fire) begin
      irq_d  = 1'b1;
      snap_d = I_COUNT;
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
      if (periodic_q) begin
        deadline_d = deadline_q + delay_q;
        if (irq_q) begin
          overrun_d = 1'b1;
        end
      end else begin
        state_d = S_FIRED;
      end
`else
      state_d = S_FIRED;
`endif
    end

    if (I_READ_EN) begin
      unique case (I_ADDR)
        A_DELAY:  rdata_d = delay_q;
        A_STATUS: rdata_d = status;
        A_SNAP:   rdata_d = snap_q;
        default:  rdata_d = '0;
      endcase
    end
  end

  // State and register file, cleared asynchronously
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q    <= S_IDLE;
      delay_q    <= '0;
      deadline_q <= '0;
      snap_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
      periodic_q <= 1'b0;
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      deadline_q <= deadline_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
`ifdef MICROSECOND_ALARM_TIMER_PERIODIC_EN
      periodic_q <= periodic_d;
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign O_READ_DATA = rdata_q;
  assign O_IRQ       = irq_q;

endmodule
